// File: rtl/counter_sequencer.sv
// Push-button sequencer for a 4-bit counter: synchronises and debounces three keys,
// then drives one-cycle load/step strobes from an IDLE/LOAD/STEP/RUN state machine.
module counter_sequencer #(
    parameter int unsigned DEB_CYCLES = 50000,
    parameter int unsigned TICK_DIV   = 25000000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       KEY_LOAD_N,
    input  logic       KEY_STEP_N,
    input  logic       KEY_RUN_N,
    input  logic [3:0] SW_D,
    output logic       load_strobe,
    output logic [3:0] load_data,
    output logic       step_strobe,
    output logic [1:0] state,
    output logic       run_led
);

    localparam int unsigned NKEYS = 3;
    localparam int unsigned CW    = 16;
    localparam int unsigned PW    = 25;
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_STEP = 2'b10,
        S_RUN  = 2'b11
    } state_t;

    // Key index 0 = load, 1 = step, 2 = run.
    logic [NKEYS-1:0] keys;
    logic [NKEYS-1:0] sync1;
    logic [NKEYS-1:0] sync2;
    logic [NKEYS-1:0] stable;
    logic [NKEYS-1:0] stable_dly;
    logic [NKEYS-1:0] evt;
    logic [CW-1:0]    cnt [NKEYS];

    assign keys = {KEY_RUN_N, KEY_STEP_N, KEY_LOAD_N};

    // Synchroniser, debounce counter and registered press-edge detector per key.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1      <= '1;
            sync2      <= '1;
            stable     <= '1;
            stable_dly <= '1;
            evt        <= '0;
            for (int i = 0; i < NKEYS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1      <= keys;
            sync2      <= sync1;
            stable_dly <= stable;
            evt        <= stable_dly & ~stable;
            for (int i = 0; i < NKEYS; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DEB_LAST) begin
                    cnt[i]    <= '0;
                    stable[i] <= sync2[i];
                end else begin
                    cnt[i] <= CW'(cnt[i] + CW'(1));
                end
            end
        end
    end

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          load_strobe_d;
    logic          step_strobe_d;
    logic [3:0]    load_data_d;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            load_strobe <= 1'b0;
            step_strobe <= 1'b0;
            load_data   <= '0;
            run_led     <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            load_strobe <= load_strobe_d;
            step_strobe <= step_strobe_d;
            load_data   <= load_data_d;
            run_led     <= (state_d == S_RUN);
        end
    end

    // Next state and registered-output values; load outranks step outranks run.
    always_comb begin
        state_d       = state_q;
        presc_d       = presc_q;
        load_strobe_d = 1'b0;
        step_strobe_d = 1'b0;
        load_data_d   = load_data;
        case (state_q)
            S_IDLE: begin
                presc_d = '0;
                if (evt[0]) begin
                    state_d       = S_LOAD;
                    load_strobe_d = 1'b1;
                    load_data_d   = SW_D;
                end else if (evt[1]) begin
                    state_d       = S_STEP;
                    step_strobe_d = 1'b1;
                end else if (evt[2]) begin
                    state_d = S_RUN;
                end
            end
            S_LOAD, S_STEP: begin
                state_d = S_IDLE;
            end
            S_RUN: begin
                if (evt[2]) begin
                    state_d = S_IDLE;
                    presc_d = '0;
                end else if (evt[0]) begin
                    load_strobe_d = 1'b1;
                    load_data_d   = SW_D;
                    presc_d       = '0;
                end else if (presc_q == TICK_LAST) begin
                    step_strobe_d = 1'b1;
                    presc_d       = '0;
                end else begin
                    presc_d = PW'(presc_q + PW'(1));
                end
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with DEB_CYCLES=4, TICK_DIV=8; expected strobes
// are queued with their cycle stamp when keys are driven and checked every cycle.
module tb_counter_sequencer;

    localparam int DEB  = 4;
    localparam int TICK = 8;
    localparam int LAT  = DEB + 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_n = 1'b1;
    logic       step_n = 1'b1;
    logic       run_n = 1'b1;
    logic [3:0] sw = 4'h0;
    logic       load_strobe;
    logic [3:0] load_data;
    logic       step_strobe;
    logic [1:0] state;
    logic       run_led;

    typedef struct {
        int         cyc;
        logic       ld;
        logic       st;
        logic [3:0] data;
        logic [1:0] fsm;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    counter_sequencer #(.DEB_CYCLES(DEB), .TICK_DIV(TICK)) dut (
        .CLOCK_50    (clk),
        .RESET_N     (rst_n),
        .KEY_LOAD_N  (load_n),
        .KEY_STEP_N  (step_n),
        .KEY_RUN_N   (run_n),
        .SW_D        (sw),
        .load_strobe (load_strobe),
        .load_data   (load_data),
        .step_strobe (step_strobe),
        .state       (state),
        .run_led     (run_led)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic push(input int c, input logic ld, input logic st,
                        input logic [3:0] d, input logic [1:0] f);
        exp_t e;
        e.cyc = c; e.ld = ld; e.st = st; e.data = d; e.fsm = f;
        sb.push_back(e);
    endtask

    // One clock; outputs sampled on the falling edge against the scoreboard head.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            chk("load_strobe", 32'(load_strobe), 32'(e.ld));
            chk("step_strobe", 32'(step_strobe), 32'(e.st));
            chk("load_data",   32'(load_data),   32'(e.data));
            chk("state",       32'(state),       32'(e.fsm));
        end else begin
            chk("quiet_load", 32'(load_strobe), 32'(0));
            chk("quiet_step", 32'(step_strobe), 32'(0));
        end
    endtask

    initial begin
        int c;
        int r;
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(state), 32'(0));
        chk("rst_load",  32'(load_strobe), 32'(0));
        chk("rst_step",  32'(step_strobe), 32'(0));
        chk("rst_data",  32'(load_data), 32'(0));
        chk("rst_led",   32'(run_led), 32'(0));
        rst_n = 1'b1;
        cyc = 0;

        // Load press captured at edge 10: strobe after edge 17, data held afterwards.
        repeat (9) tick();
        sw = 4'h9;
        push(17, 1'b1, 1'b0, 4'h9, 2'b01);
        push(18, 1'b0, 1'b0, 4'h9, 2'b00);
        load_n = 1'b0;
        repeat (8) tick();
        sw = 4'h5;
        tick();
        load_n = 1'b1;
        repeat (10) tick();

        // Three-cycle glitch on step: filtered out.
        step_n = 1'b0;
        repeat (3) tick();
        step_n = 1'b1;
        repeat (12) tick();
        chk("glitch_state", 32'(state), 32'(0));

        // Load and step together: load wins; step needs a fresh press.
        c = cyc;
        sw = 4'hA;
        push(c + LAT, 1'b1, 1'b0, 4'hA, 2'b01);
        push(c + LAT + 1, 1'b0, 1'b0, 4'hA, 2'b00);
        load_n = 1'b0;
        step_n = 1'b0;
        repeat (12) tick();
        load_n = 1'b1;
        step_n = 1'b1;
        repeat (10) tick();
        c = cyc;
        push(c + LAT, 1'b0, 1'b1, 4'hA, 2'b10);
        push(c + LAT + 1, 1'b0, 1'b0, 4'hA, 2'b00);
        step_n = 1'b0;
        repeat (10) tick();
        step_n = 1'b1;
        repeat (12) tick();

        // RUN for 42 cycles: five step pulses, first TICK cycles after entry.
        c = cyc;
        push(c + LAT, 1'b0, 1'b0, 4'hA, 2'b11);
        for (int i = 1; i <= 5; i++) push(c + LAT + i * TICK, 1'b0, 1'b1, 4'hA, 2'b11);
        push(c + LAT + 42, 1'b0, 1'b0, 4'hA, 2'b00);
        run_n = 1'b0;
        repeat (LAT) tick();
        chk("run_led_on", 32'(run_led), 32'(1));
        repeat (2) tick();
        run_n = 1'b1;
        repeat (32) tick();
        run_n = 1'b0;
        repeat (LAT) tick();
        chk("run_led_off", 32'(run_led), 32'(0));
        run_n = 1'b1;
        repeat (12) tick();

        // Load lands on prescaler terminal count: load wins, prescaler restarts.
        c = cyc;
        r = c + LAT;
        sw = 4'h3;
        push(r, 1'b0, 1'b0, 4'hA, 2'b11);
        push(r + TICK, 1'b1, 1'b0, 4'h3, 2'b11);
        push(r + 2 * TICK, 1'b0, 1'b1, 4'h3, 2'b11);
        run_n = 1'b0;
        repeat (LAT) tick();
        load_n = 1'b0;
        repeat (10) tick();
        load_n = 1'b1;
        run_n = 1'b1;
        repeat (11) tick();

        // Asynchronous reset with the prescaler at 5.
        rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'(0));
        chk("arst_load",  32'(load_strobe), 32'(0));
        chk("arst_step",  32'(step_strobe), 32'(0));
        chk("arst_data",  32'(load_data), 32'(0));
        chk("arst_led",   32'(run_led), 32'(0));
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (50) tick();
        chk("post_rst_state", 32'(state), 32'(0));
        chk("post_rst_led",   32'(run_led), 32'(0));
        chk("sb_drained",     32'(sb.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
